// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode and immediate-format constants.
// Reused by the immediate generator, hazard and control units.
package imm_gen_pipe_pkg;

   localparam logic [6:0] OPC_LOAD        = 7'b0000011;
   localparam logic [6:0] OPC_ARITH_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC       = 7'b0010111;
   localparam logic [6:0] OPC_ARITH_IMM_W = 7'b0011011;
   localparam logic [6:0] OPC_STORE       = 7'b0100011;
   localparam logic [6:0] OPC_ARITH       = 7'b0110011;
   localparam logic [6:0] OPC_LUI         = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH      = 7'b1100011;
   localparam logic [6:0] OPC_JALR        = 7'b1100111;
   localparam logic [6:0] OPC_JAL         = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM      = 7'b1110011;

   localparam logic [2:0] FMT_NONE  = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_SHAMT = 3'd2;
   localparam logic [2:0] FMT_S     = 3'd3;
   localparam logic [2:0] FMT_B     = 3'd4;
   localparam logic [2:0] FMT_U     = 3'd5;
   localparam logic [2:0] FMT_J     = 3'd6;

   // funct3 values selecting the shift-immediate encodings
   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready link carrying instructions in and immediates out.
// master drives instructions and consumes results; slave is the generator.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_fmt;
   logic             out_illegal;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_inst, in_tag, out_ready,
      input  in_ready, out_valid, out_imm,
      input  out_fmt, out_illegal, out_tag
   );

   modport slave (
      input  in_valid, in_inst, in_tag, out_ready,
      output in_ready, out_valid, out_imm,
      output out_fmt, out_illegal, out_tag
   );
endinterface

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: inst -> {imm, fmt, illegal}.
// Shift amounts are zero-extended; all other formats sign-extend.
module imm_decode_comb
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [5:0]      shamt;
   logic            is_shift;

   assign imm_i = XLEN'($signed(inst[31:20]));
   assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
   assign imm_b = XLEN'($signed({inst[31], inst[7],
                                 inst[30:25], inst[11:8],
                                 1'b0}));
   assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({inst[31], inst[19:12],
                                 inst[20], inst[30:21],
                                 1'b0}));

   // RV64 widens the shift amount to 6 bits for the full-width ops
   assign shamt = (XLEN == 64) ? inst[25:20]
                               : {1'b0, inst[24:20]};

   assign is_shift = (inst[14:12] == F3_SLL) ||
                     (inst[14:12] == F3_SRX);

   // Classify by opcode and select the matching immediate
   always_comb begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b0;
      unique case (inst[6:0])
         OPC_ARITH_IMM: begin
            if (is_shift) begin
               fmt = FMT_SHAMT;
               imm = XLEN'(shamt);
            end else begin
               fmt = FMT_I;
               imm = imm_i;
            end
         end
         OPC_ARITH_IMM_W: begin
            if (XLEN == 64) begin
               if (is_shift) begin
                  fmt = FMT_SHAMT;
                  imm = XLEN'(inst[24:20]);
               end else begin
                  fmt = FMT_I;
                  imm = imm_i;
               end
            end else begin
               illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            fmt = FMT_I;
            imm = imm_i;
         end
         OPC_STORE: begin
            fmt = FMT_S;
            imm = imm_s;
         end
         OPC_BRANCH: begin
            fmt = FMT_B;
            imm = imm_b;
         end
         OPC_LUI, OPC_AUIPC: begin
            fmt = FMT_U;
            imm = imm_u;
         end
         OPC_JAL: begin
            fmt = FMT_J;
            imm = imm_j;
         end
         OPC_ARITH, OPC_SYSTEM: begin
            fmt = FMT_NONE;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a two-entry head/skid buffer.
// Decode happens before the registers; the top only moves entries.
module imm_gen_pipe
   import imm_gen_pipe_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input logic            clk,
   input logic            reset,
   input logic            flush,
   imm_gen_pipe_if.slave  bus
);

   logic [XLEN-1:0]  dec_imm;
   logic [2:0]       dec_fmt;
   logic             dec_ill;

   logic             head_valid_q, head_valid_d;
   logic [XLEN-1:0]  head_imm_q,   head_imm_d;
   logic [2:0]       head_fmt_q,   head_fmt_d;
   logic             head_ill_q,   head_ill_d;
   logic [TAG_W-1:0] head_tag_q,   head_tag_d;

   logic             skid_valid_q, skid_valid_d;
   logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
   logic [2:0]       skid_fmt_q,   skid_fmt_d;
   logic             skid_ill_q,   skid_ill_d;
   logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

   logic             in_ready_q,   in_ready_d;
   logic             accept;
   logic             drain;

   imm_decode_comb #(.XLEN(XLEN)) u_dec (
      .inst    (bus.in_inst),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   assign accept = bus.in_valid && in_ready_q && !flush;
   assign drain  = head_valid_q && bus.out_ready;

   // Next-state for head/skid: flush wins, then refill head, else skid
   always_comb begin
      head_valid_d = head_valid_q;
      head_imm_d   = head_imm_q;
      head_fmt_d   = head_fmt_q;
      head_ill_d   = head_ill_q;
      head_tag_d   = head_tag_q;
      skid_valid_d = skid_valid_q;
      skid_imm_d   = skid_imm_q;
      skid_fmt_d   = skid_fmt_q;
      skid_ill_d   = skid_ill_q;
      skid_tag_d   = skid_tag_q;
      if (flush) begin
         head_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!head_valid_q || drain) begin
         if (skid_valid_q) begin
            head_valid_d = 1'b1;
            head_imm_d   = skid_imm_q;
            head_fmt_d   = skid_fmt_q;
            head_ill_d   = skid_ill_q;
            head_tag_d   = skid_tag_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            head_valid_d = 1'b1;
            head_imm_d   = dec_imm;
            head_fmt_d   = dec_fmt;
            head_ill_d   = dec_ill;
            head_tag_d   = bus.in_tag;
         end else begin
            head_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_imm_d   = dec_imm;
         skid_fmt_d   = dec_fmt;
         skid_ill_d   = dec_ill;
         skid_tag_d   = bus.in_tag;
      end
      in_ready_d = !skid_valid_d;
   end

   // State registers; reset clears both entries and opens the input
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_valid_q <= 1'b0;
         head_imm_q   <= '0;
         head_fmt_q   <= FMT_NONE;
         head_ill_q   <= 1'b0;
         head_tag_q   <= '0;
         skid_valid_q <= 1'b0;
         skid_imm_q   <= '0;
         skid_fmt_q   <= FMT_NONE;
         skid_ill_q   <= 1'b0;
         skid_tag_q   <= '0;
         in_ready_q   <= 1'b1;
      end else begin
         head_valid_q <= head_valid_d;
         head_imm_q   <= head_imm_d;
         head_fmt_q   <= head_fmt_d;
         head_ill_q   <= head_ill_d;
         head_tag_q   <= head_tag_d;
         skid_valid_q <= skid_valid_d;
         skid_imm_q   <= skid_imm_d;
         skid_fmt_q   <= skid_fmt_d;
         skid_ill_q   <= skid_ill_d;
         skid_tag_q   <= skid_tag_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = head_valid_q;
   assign bus.out_imm     = head_imm_q;
   assign bus.out_fmt     = head_fmt_q;
   assign bus.out_illegal = head_ill_q;
   assign bus.out_tag     = head_tag_q;

endmodule
